// File: rtl/instr_fetch_pkg.sv
// Shared ISA definitions for the fetch unit, the ROM image and the execute stage:
// opcode constants, instruction field positions and fetch FSM state encodings.
package instr_fetch_pkg;

    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_OUT  = 4'b1111;
    localparam logic [3:0] OP_HALT = 4'b1110;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter: load (redirect) beats increment, otherwise hold.
// The counter wraps naturally at 2^ADDR_W.
module pc_reg #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_addr;
        end else if (inc) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives the program ROM address, registers the returned
// word with its PC, decodes fields from the registered word and detects HALT.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int INST_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_data,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [3:0]        opcode,
    output logic [2:0]        rd,
    output logic [7:0]        imm8,
    output logic              halted
);

    fetch_state_e      state_q, state_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic [ADDR_W-1:0] pc;
    logic              pc_load;
    logic              pc_inc;

    pc_reg #(.ADDR_W(ADDR_W)) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (pc_load),
        .load_addr (redirect_addr),
        .inc       (pc_inc),
        .pc        (pc)
    );

    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        pc_load      = 1'b0;
        pc_inc       = 1'b0;
        if (!en) begin
            state_d      = ST_IDLE;
            inst_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d      = ST_RUN;
                    inst_valid_d = 1'b0;
                end
                ST_RUN, ST_HALT: begin
                    if (redirect_valid) begin
                        pc_load      = 1'b1;
                        inst_valid_d = 1'b0;
                        state_d      = ST_RUN;
                    end else if (!stall) begin
                        if (state_q == ST_HALT) begin
                            // Halt word has now been presented for one accepted cycle.
                            inst_valid_d = 1'b0;
                        end else begin
                            inst_d       = rom_data;
                            inst_pc_d    = pc;
                            inst_valid_d = 1'b1;
                            if (rom_data[OPC_MSB:OPC_LSB] == OP_HALT) begin
                                state_d = ST_HALT;
                            end else begin
                                pc_inc = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    inst_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign rom_addr   = pc;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;
    assign halted     = (state_q == ST_HALT);
    assign opcode     = inst_q[OPC_MSB:OPC_LSB];
    assign rd         = inst_q[RD_MSB:RD_LSB];
    assign imm8       = inst_q[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a combinational ROM model, expected results
// queued as each cycle is driven and compared after the edge.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int AW = 4;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          stall;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic [AW-1:0] rom_addr;
    logic [IW-1:0] rom_data;
    logic          inst_valid;
    logic [IW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic [3:0]    opcode;
    logic [2:0]    rd;
    logic [7:0]    imm8;
    logic          halted;

    logic [IW-1:0] rom [16];
    logic [IW-1:0] saved_word;
    logic [AW-1:0] next_pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string         tag;
        logic          v;
        logic [AW-1:0] pc;
        logic [IW-1:0] word;
        logic          h;
        logic [AW-1:0] ra;
    } exp_t;

    exp_t sb[$];

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(AW), .INST_W(IW)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .opcode         (opcode),
        .rd             (rd),
        .imm8           (imm8),
        .halted         (halted)
    );

    task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Queue the expectation for this cycle, advance one edge, then compare.
    task automatic expect_cycle(input string tag, input logic v, input logic [AW-1:0] pc,
                                input logic h, input logic [AW-1:0] ra);
        exp_t e;
        e.tag  = tag;
        e.v    = v;
        e.pc   = pc;
        e.word = rom[pc];
        e.h    = h;
        e.ra   = ra;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        $display("txn %-10s valid=%0b inst_pc=%0d inst=%h halted=%0b rom_addr=%0d",
                 e.tag, inst_valid, inst_pc, inst, halted, rom_addr);
        chk({e.tag, ":valid"}, IW'(inst_valid), IW'(e.v));
        chk({e.tag, ":halted"}, IW'(halted), IW'(e.h));
        chk({e.tag, ":rom_addr"}, IW'(rom_addr), IW'(e.ra));
        if (e.v) begin
            chk({e.tag, ":inst_pc"}, IW'(inst_pc), IW'(e.pc));
            chk({e.tag, ":inst"}, inst, e.word);
            chk({e.tag, ":opcode"}, IW'(opcode), IW'(e.word[15:12]));
            chk({e.tag, ":rd"}, IW'(rd), IW'(e.word[11:9]));
            chk({e.tag, ":imm8"}, IW'(imm8), IW'(e.word[7:0]));
        end
    endtask

    task automatic fetch(input string tag);
        expect_cycle(tag, 1'b1, next_pc, 1'b0, AW'(next_pc + AW'(1)));
        next_pc = AW'(next_pc + AW'(1));
    endtask

    // Fetch until inst_pc == target (bounded to one trip around the ROM).
    task automatic run_to(input logic [AW-1:0] target);
        repeat (16) begin
            if (next_pc != AW'(target + AW'(1))) fetch("run");
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) rom[i] = {OP_ADDI, 3'(i % 8), 1'b0, 8'(i)};
            else            rom[i] = {OP_OUT,  3'(i % 8), 1'b0, 8'(i * 3)};
        end
        rom[0] = 16'h1203;

        rst            = 1'b1;
        en             = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        next_pc        = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset:valid", IW'(inst_valid), 16'h0);
        chk("reset:inst", inst, 16'h0);
        chk("reset:inst_pc", IW'(inst_pc), 16'h0);
        chk("reset:halted", IW'(halted), 16'h0);
        chk("reset:rom_addr", IW'(rom_addr), 16'h0);

        // Straight-line program and wrap.
        en = 1'b1;
        expect_cycle("enable", 1'b0, '0, 1'b0, '0);
        fetch("fetch");
        chk("decode:opcode", IW'(opcode), 16'h1);
        chk("decode:rd", IW'(rd), 16'h1);
        chk("decode:imm8", IW'(imm8), 16'h3);
        for (int i = 1; i < 16; i++) fetch("fetch");
        for (int i = 0; i < 6; i++) fetch("wrap");

        // Stall for three cycles at inst_pc=5.
        stall = 1'b1;
        repeat (3) expect_cycle("stall", 1'b1, 4'd5, 1'b0, 4'd6);
        stall = 1'b0;
        fetch("unstall");

        // Redirect with simultaneous stall at inst_pc=3.
        run_to(4'd3);
        redirect_valid = 1'b1;
        redirect_addr  = 4'd12;
        stall          = 1'b1;
        expect_cycle("redir", 1'b0, '0, 1'b0, 4'd12);
        redirect_valid = 1'b0;
        stall          = 1'b0;
        next_pc        = 4'd12;
        fetch("redir_tgt");

        // Halt word at address 7.
        saved_word = rom[7];
        rom[7]     = 16'hE000;
        run_to(4'd6);
        expect_cycle("halt_word", 1'b1, 4'd7, 1'b1, 4'd7);
        expect_cycle("halted", 1'b0, '0, 1'b1, 4'd7);
        expect_cycle("halted", 1'b0, '0, 1'b1, 4'd7);
        redirect_valid = 1'b1;
        redirect_addr  = 4'd0;
        expect_cycle("halt_redir", 1'b0, '0, 1'b0, 4'd0);
        redirect_valid = 1'b0;
        rom[7]         = saved_word;
        next_pc        = 4'd0;
        fetch("resume");

        // Enable toggle at inst_pc=9.
        run_to(4'd9);
        en = 1'b0;
        repeat (2) expect_cycle("disabled", 1'b0, '0, 1'b0, 4'd10);
        en = 1'b1;
        expect_cycle("reenable", 1'b0, '0, 1'b0, 4'd10);
        fetch("resume_en");

        // Asynchronous reset pulse between edges at inst_pc=11.
        run_to(4'd11);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst:rom_addr", IW'(rom_addr), 16'h0);
        chk("async_rst:valid", IW'(inst_valid), 16'h0);
        chk("async_rst:halted", IW'(halted), 16'h0);
        chk("async_rst:inst", inst, 16'h0);
        chk("async_rst:inst_pc", IW'(inst_pc), 16'h0);
        #2;
        rst = 1'b0;
        expect_cycle("post_rst", 1'b0, '0, 1'b0, 4'd0);
        next_pc = 4'd0;
        fetch("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
